temporal_encoder: RTL and testbench

Builds N-gram hypervectors from the stream of spatially encoded hypervectors. Sits directly downstream of the spatial encoder and upstream of the associative memory. Each N-gram is the hypervector at time t XORed with the permuted hypervectors from the previous N-1 time steps. Holds N-1 history registers and one output register, with valid/ready on both sides.

---
 rtl/temporal_encoder_if.sv | 34 +++
 rtl/temporal_encoder.sv | 114 +++++++++++
 tb/tb_temporal_encoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/temporal_encoder_if.sv
// Hypervector stream bundle between the spatial encoder, the temporal encoder
// and the associative memory. The slave modport is the temporal encoder's view.
// The master modport is the surrounding environment's view.
interface temporal_encoder_if #(
    parameter int HV_DIMENSION = 2000
);
    logic                    ValidIn_SI;
    logic                    ReadyOut_SO;
    logic [0:HV_DIMENSION-1] HypervectorIn_DI;
    logic                    FlushIn_SI;
    logic                    ValidOut_SO;
    logic                    ReadyIn_SI;
    logic [0:HV_DIMENSION-1] HypervectorOut_DO;

    modport slave (
        input  ValidIn_SI,
        input  HypervectorIn_DI,
        input  FlushIn_SI,
        input  ReadyIn_SI,
        output ReadyOut_SO,
        output ValidOut_SO,
        output HypervectorOut_DO
    );

    modport master (
        output ValidIn_SI,
        output HypervectorIn_DI,
        output FlushIn_SI,
        output ReadyIn_SI,
        input  ReadyOut_SO,
        input  ValidOut_SO,
        input  HypervectorOut_DO
    );
endinterface

// File: rtl/temporal_encoder.sv
// N-gram builder: XORs the current spatial hypervector with the previous N-1
// accepted hypervectors, each rotated by its age (rho^age). History only moves
// on an accept, so gaps in the input stream do not age it. NGRAM_SIZE must be
// in 2..8, and HV_DIMENSION must be at least NGRAM_SIZE.
module temporal_encoder #(
    parameter int HV_DIMENSION = 2000,
    parameter int NGRAM_SIZE   = 3
) (
    input  logic              Clk_CI,
    input  logic              Reset_RBI,
    temporal_encoder_if.slave bus_io
);
    localparam int CW = $clog2(NGRAM_SIZE);
    localparam int NH = NGRAM_SIZE - 1;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [0:HV_DIMENSION-1] hist_q [NH];
    logic [0:HV_DIMENSION-1] out_q;
    logic                    valid_q;

    logic                    ready;
    logic                    accept;
    logic                    load;
    logic [0:HV_DIMENSION-1] perm_hist [NH];
    logic [0:HV_DIMENSION-1] ngram_d;

    // Ready is held low during reset and also while an undelivered N-gram is stalled.
    assign ready  = Reset_RBI && (!valid_q || bus_io.ReadyIn_SI);
    assign accept = bus_io.ValidIn_SI && ready;
    // A flush turns the accepted vector into the first vector of a new sequence,
    // so it never completes an N-gram.
    assign load   = accept && (state_q == STREAM) && !bus_io.FlushIn_SI;

    // History entry gi is (gi+1) steps old. Rotate it toward higher index by that amount.
    for (genvar gi = 0; gi < NH; gi++) begin : g_perm
        for (genvar gk = 0; gk < HV_DIMENSION; gk++) begin : g_bit
            assign perm_hist[gi][gk] =
                hist_q[gi][(gk + HV_DIMENSION - ((gi + 1) % HV_DIMENSION)) % HV_DIMENSION];
        end
    end

    // Combine the current input with all aged history vectors.
    always_comb begin
        ngram_d = bus_io.HypervectorIn_DI;
        for (int i = 0; i < NH; i++) begin
            ngram_d = ngram_d ^ perm_hist[i];
        end
    end

    // Control FSM, fill counter, history shift register and output register.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            state_q <= FILL;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
            for (int i = 0; i < NH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            // Output register: a new N-gram replaces the old one during a handshake.
            // Otherwise the handshake retires the old N-gram.
            if (load) begin
                out_q   <= ngram_d;
                valid_q <= 1'b1;
            end else if (bus_io.ReadyIn_SI) begin
                valid_q <= 1'b0;
            end

            if (bus_io.FlushIn_SI) begin
                for (int i = 0; i < NH; i++) begin
                    hist_q[i] <= '0;
                end
                if (accept) begin
                    hist_q[0] <= bus_io.HypervectorIn_DI;
                    cnt_q     <= CW'(1);
                    state_q   <= (NGRAM_SIZE == 2) ? STREAM : FILL;
                end else begin
                    cnt_q   <= '0;
                    state_q <= FILL;
                end
            end else if (accept) begin
                for (int i = NH - 1; i > 0; i--) begin
                    hist_q[i] <= hist_q[i-1];
                end
                hist_q[0] <= bus_io.HypervectorIn_DI;
                case (state_q)
                    FILL: begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(NGRAM_SIZE - 2)) begin
                            state_q <= STREAM;
                        end
                    end
                    STREAM: begin
                        state_q <= STREAM;
                    end
                    default: begin
                        state_q <= FILL;
                    end
                endcase
            end
        end
    end

    assign bus_io.ReadyOut_SO       = ready;
    assign bus_io.ValidOut_SO       = valid_q;
    assign bus_io.HypervectorOut_DO = out_q;
endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder (D=8, N=3). Vectors are written in hex
// with bit 0 as the MSB. Expected N-grams are queued when the stimulus is issued.
// A monitor pops one expected value at every output handshake and compares it.
module tb_temporal_encoder;
    localparam int D = 8;
    localparam int N = 3;

    logic clk;
    logic rst_n;

    int compares;
    int errors;

    logic [0:D-1] exp_q [$];

    temporal_encoder_if #(.HV_DIMENSION(D)) bus ();

    temporal_encoder #(
        .HV_DIMENSION(D),
        .NGRAM_SIZE  (N)
    ) dut (
        .Clk_CI   (clk),
        .Reset_RBI(rst_n),
        .bus_io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:D-1] rho(input logic [0:D-1] x);
        rho = {x[D-1], x[0:D-2]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compares++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Present one vector and hold it until the DUT accepts it.
    // The task is entered and left 1 time unit after a rising edge.
    task automatic send(input logic [0:D-1] v, input logic fl);
        int waited;
        waited = 0;
        bus.ValidIn_SI       = 1'b1;
        bus.HypervectorIn_DI = v;
        bus.FlushIn_SI       = fl;
        @(negedge clk);
        while (!bus.ReadyOut_SO && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", {31'd0, bus.ReadyOut_SO}, 32'd1);
        @(posedge clk);
        #1;
        bus.ValidIn_SI = 1'b0;
        bus.FlushIn_SI = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expected N-gram.
    initial begin
        logic [0:D-1] e;
        forever begin
            @(negedge clk);
            if (bus.ValidOut_SO && bus.ReadyIn_SI) begin
                compares++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got %h, required no output", bus.HypervectorOut_DO);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.HypervectorOut_DO !== e) begin
                        errors++;
                        $display("FAIL out_data: got %h, required %h", bus.HypervectorOut_DO, e);
                    end else begin
                        $display("out  %h", bus.HypervectorOut_DO);
                    end
                end
            end
        end
    end

    initial begin
        logic [0:D-1] stream_v [12];
        logic [0:D-1] h0;
        logic [0:D-1] h1;
        logic [0:D-1] e;
        stream_v = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h81, 8'h7E,
                     8'h55, 8'hAA, 8'h12, 8'h34, 8'hC3, 8'h99};
        compares = 0;
        errors   = 0;

        // Reset state
        rst_n                = 1'b0;
        bus.ValidIn_SI       = 1'b0;
        bus.HypervectorIn_DI = '0;
        bus.FlushIn_SI       = 1'b0;
        bus.ReadyIn_SI       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {31'd0, bus.ReadyOut_SO}, 32'd0);
        check("rst_valid",  {31'd0, bus.ValidOut_SO}, 32'd0);
        check("rst_data",   {24'd0, bus.HypervectorOut_DO}, 32'h00);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.ReadyIn_SI = 1'b1;

        // Basic stream: 80, 80, 00 -> 60. Then FF -> DF.
        send(8'h80, 1'b0);
        send(8'h80, 1'b0);
        exp_q.push_back(8'h60);
        send(8'h00, 1'b0);
        exp_q.push_back(8'hDF);
        send(8'hFF, 1'b0);
        idle(3);

        // Wrap-around: flush+01, 00, 00 -> 40 (rho^2 of bit 7 lands on bit 1)
        send(8'h01, 1'b1);
        send(8'h00, 1'b0);
        exp_q.push_back(8'h40);
        send(8'h00, 1'b0);
        idle(3);

        // Backpressure: hold the 60 for 5 cycles while FF waits at the input
        send(8'h80, 1'b1);
        send(8'h80, 1'b0);
        exp_q.push_back(8'h60);
        send(8'h00, 1'b0);
        bus.ReadyIn_SI       = 1'b0;
        bus.ValidIn_SI       = 1'b1;
        bus.HypervectorIn_DI = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", {31'd0, bus.ReadyOut_SO}, 32'd0);
            check("bp_valid", {31'd0, bus.ValidOut_SO}, 32'd1);
            check("bp_data",  {24'd0, bus.HypervectorOut_DO}, 32'h60);
        end
        @(posedge clk);
        #1;
        bus.ReadyIn_SI = 1'b1;
        exp_q.push_back(8'hDF);
        send(8'hFF, 1'b0);
        exp_q.push_back(8'hFF);
        send(8'h00, 1'b0);
        idle(3);

        // Flush with simultaneous accept while a 60 is still pending
        send(8'h80, 1'b1);
        send(8'h80, 1'b0);
        exp_q.push_back(8'h60);
        send(8'h00, 1'b0);
        bus.ReadyIn_SI = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("fl_pending_valid", {31'd0, bus.ValidOut_SO}, 32'd1);
            check("fl_pending_data",  {24'd0, bus.HypervectorOut_DO}, 32'h60);
        end
        @(posedge clk);
        #1;
        bus.ReadyIn_SI = 1'b1;
        send(8'h80, 1'b1);
        send(8'h80, 1'b0);
        exp_q.push_back(8'h60);
        send(8'h00, 1'b0);
        idle(3);

        // Continuous streaming: one output per cycle, and valid never drops
        h0 = '0;
        h1 = '0;
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) begin
                e = stream_v[i] ^ rho(h0) ^ rho(rho(h1));
                exp_q.push_back(e);
            end
            send(stream_v[i], (i == 0));
            h1 = (i == 0) ? '0 : h0;
            h0 = stream_v[i];
            if (i >= 2) check("stream_valid", {31'd0, bus.ValidOut_SO}, 32'd1);
        end
        idle(3);

        // Reset mid-stream with a pending output (11, 22, 33 -> 66, which is discarded)
        bus.ReadyIn_SI = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        @(negedge clk);
        check("mid_valid", {31'd0, bus.ValidOut_SO}, 32'd1);
        check("mid_data",  {24'd0, bus.HypervectorOut_DO}, 32'h66);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {31'd0, bus.ReadyOut_SO}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_valid", {31'd0, bus.ValidOut_SO}, 32'd0);
        check("mid_rst_data",  {24'd0, bus.HypervectorOut_DO}, 32'h00);
        rst_n          = 1'b1;
        bus.ReadyIn_SI = 1'b1;
        send(8'h80, 1'b0);
        send(8'h80, 1'b0);
        exp_q.push_back(8'h60);
        send(8'h00, 1'b0);
        idle(5);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", compares, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
